// File: rtl/text_pixel_pipe.sv
// Text-mode pixel pipeline: 8x16 character cells from packed VRAM plus a font ROM.
// Three-stage pipe from drawX/drawY to registered RGB, with blinking cursor.
//
// Ports:
//   pixel_clk, reset          sole clock, async active-high reset
//   drawX, drawY              current pixel position from the sync generator
//   hs_in, vs_in, vde_in      sync / active-video, delayed 3 clocks to *_out
//   vram_addr / vram_rdata    word address (comb) / word data one clock later
//   font_addr / font_data     {code, glyph_row} (comb) / glyph row one clock later
//   fg_color, bg_color        12-bit {R,G,B} colors, pipelined with the pixel
//   cursor_x/y, cursor_en     cursor cell and enable
//   red, green, blue          registered pixel color, zero outside active video
//   hs_out, vs_out, vde_out   delayed sync / active-video
module text_pixel_pipe #(
    parameter int H_CHARS = 80,
    parameter int V_CHARS = 30
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        vde_in,
    output logic [9:0]  vram_addr,
    input  logic [31:0] vram_rdata,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    input  logic        cursor_en,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        vde_out
);

    localparam logic [10:0] X_LIMIT = 11'(8 * H_CHARS);
    localparam logic [10:0] Y_LIMIT = 11'(16 * V_CHARS);
    localparam logic [11:0] H_W     = 12'(H_CHARS);
    localparam logic [7:0]  H_CMP   = 8'(H_CHARS);
    localparam logic [5:0]  V_CMP   = 6'(V_CHARS);

    // ---------------- stage 0: cell lookup ----------------
    logic [6:0]  col;
    logic [5:0]  row;
    logic [3:0]  glyph_row;
    logic [2:0]  bit_idx;
    logic        in_range;
    logic [11:0] char_idx;
    logic        cursor_ok;
    logic        cursor_hit;

    // blink state
    logic        vs_prev;
    logic [4:0]  frame_cnt;
    logic        blink_on;

    assign col       = drawX[9:3];
    assign row       = drawY[9:4];
    assign glyph_row = drawY[3:0];
    assign bit_idx   = drawX[2:0];

    assign in_range = ({1'b0, drawX} < X_LIMIT) &&
                      ({1'b0, drawY} < Y_LIMIT);

    // Four characters share a VRAM word; low two bits pick the byte.
    assign char_idx  = ({6'd0, row} * H_W) + {5'd0, col};
    assign vram_addr = in_range ? char_idx[11:2] : 10'd0;

    // Cursor coordinates outside the text grid can never match.
    assign cursor_ok = ({1'b0, cursor_x} < H_CMP) &&
                       ({1'b0, cursor_y} < V_CMP);

    // Cursor underline covers the bottom two glyph rows of the cell.
    assign cursor_hit = cursor_en && blink_on && cursor_ok && in_range &&
                        (col == cursor_x) &&
                        (row == {1'b0, cursor_y}) &&
                        (glyph_row[3:1] == 3'b111);

    // ---------------- stage 1: byte select, font address ----------------
    logic [1:0]  sel_s1;
    logic [3:0]  grow_s1;
    logic [2:0]  bit_s1;
    logic        hit_s1;
    logic [11:0] fg_s1;
    logic [11:0] bg_s1;
    logic [7:0]  char_byte;

    always_comb begin
        char_byte = vram_rdata[7:0];
        unique case (sel_s1)
            2'd0: char_byte = vram_rdata[7:0];
            2'd1: char_byte = vram_rdata[15:8];
            2'd2: char_byte = vram_rdata[23:16];
            2'd3: char_byte = vram_rdata[31:24];
        endcase
    end

    assign font_addr = {char_byte[6:0], grow_s1};

    // ---------------- stage 2: pixel select ----------------
    logic [2:0]  bit_s2;
    logic        inv_s2;
    logic        hit_s2;
    logic [11:0] fg_s2;
    logic [11:0] bg_s2;
    logic        glyph_bit;
    logic        pixel;

    // font_data bit7 is the leftmost pixel of the cell.
    assign glyph_bit = font_data[3'd7 - bit_s2];
    assign pixel     = glyph_bit ^ inv_s2 ^ hit_s2;

    // ---------------- sync delay and output registers ----------------
    logic [2:0] hs_d;
    logic [2:0] vs_d;
    logic [2:0] vde_d;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sel_s1  <= '0;
            grow_s1 <= '0;
            bit_s1  <= '0;
            hit_s1  <= 1'b0;
            fg_s1   <= '0;
            bg_s1   <= '0;
            bit_s2  <= '0;
            inv_s2  <= 1'b0;
            hit_s2  <= 1'b0;
            fg_s2   <= '0;
            bg_s2   <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
            vde_d   <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            sel_s1  <= char_idx[1:0];
            grow_s1 <= glyph_row;
            bit_s1  <= bit_idx;
            hit_s1  <= cursor_hit;
            fg_s1   <= fg_color;
            bg_s1   <= bg_color;

            bit_s2  <= bit_s1;
            inv_s2  <= char_byte[7];
            hit_s2  <= hit_s1;
            fg_s2   <= fg_s1;
            bg_s2   <= bg_s1;

            hs_d    <= {hs_d[1:0], hs_in};
            vs_d    <= {vs_d[1:0], vs_in};
            vde_d   <= {vde_d[1:0], vde_in};

            // vde_d[1] becomes vde_out on this same edge.
            if (vde_d[1]) begin
                {red, green, blue} <= pixel ? fg_s2 : bg_s2;
            end else begin
                {red, green, blue} <= 12'd0;
            end
        end
    end

    assign hs_out  = hs_d[2];
    assign vs_out  = vs_d[2];
    assign vde_out = vde_d[2];

    // ---------------- frame counter / blink ----------------
    // 30 vsync falls per blink phase gives a 60-frame blink period.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vs_prev   <= 1'b0;
            frame_cnt <= 5'd0;
            blink_on  <= 1'b1;
        end else begin
            vs_prev <= vs_in;
            if (vs_prev && !vs_in) begin
                if (frame_cnt == 5'd29) begin
                    frame_cnt <= 5'd0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Self-checking bench for text_pixel_pipe with VRAM and font ROM models.
// Directed vector table plus hand sequences for lookup, cursor blink, sync, reset.
module tb_text_pixel_pipe;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic        hs_in;
    logic        vs_in;
    logic        vde_in;
    logic [9:0]  vram_addr;
    logic [31:0] vram_rdata;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_en;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hs_out;
    logic        vs_out;
    logic        vde_out;

    text_pixel_pipe dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .drawX     (drawX),
        .drawY     (drawY),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .vde_in    (vde_in),
        .vram_addr (vram_addr),
        .vram_rdata(vram_rdata),
        .font_addr (font_addr),
        .font_data (font_data),
        .fg_color  (fg_color),
        .bg_color  (bg_color),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_en (cursor_en),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .vde_out   (vde_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    logic [31:0] vram [0:1023];
    logic [7:0]  font [0:2047];

    // Synchronous-read memories: data one clock after the address.
    always @(posedge pixel_clk) begin
        vram_rdata <= vram[vram_addr];
        font_data  <= font[font_addr];
    end

    localparam logic [11:0] FG = 12'hF00;
    localparam logic [11:0] BG = 12'h00F;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vde;
        logic [11:0] rgb;
    } vec_t;

    vec_t tv[$];
    int total = 0;
    int bad   = 0;
    logic hs_hist [0:15];

    function automatic void add(input logic [9:0] x, input logic [9:0] y,
                                input logic vde, input logic [11:0] rgb);
        vec_t v;
        v.x   = x;
        v.y   = y;
        v.vde = vde;
        v.rgb = rgb;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One active pixel followed by idle cycles, result after the third edge.
    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] exp, input string name);
        drawX  = x;
        drawY  = y;
        vde_in = 1'b1;
        tick();
        vde_in = 1'b0;
        tick();
        tick();
        check(name, {20'd0, red, green, blue}, {20'd0, exp});
    endtask

    task automatic vs_pulses(input int n);
        repeat (n) begin
            vs_in = 1'b1;
            tick();
            vs_in = 1'b0;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 32'd0;
        for (int i = 0; i < 2048; i++) font[i] = 8'd0;
        vram[0]  = 32'h00C1_4100;
        vram[40] = 32'h0042_0000;
        for (int r = 0; r < 16; r++) font[11'h410 + r] = 8'h80;
        font[11'h423] = 8'h40;

        reset     = 1'b1;
        drawX     = '0;
        drawY     = '0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        vde_in    = 1'b0;
        fg_color  = FG;
        bg_color  = BG;
        cursor_x  = 7'd5;
        cursor_y  = 5'd2;
        cursor_en = 1'b1;
        tick();
        tick();
        check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check("reset_sync", {29'd0, hs_out, vs_out, vde_out}, 32'd0);
        reset = 1'b0;
        tick();

        // char 0x41 glyph 0x80 at col 1, inverted copy at col 2
        for (int i = 0; i < 8; i++)
            add(10'(8 + i), 10'd0, 1'b1, (i == 0) ? FG : BG);
        for (int i = 0; i < 8; i++)
            add(10'(16 + i), 10'd0, 1'b1, (i == 0) ? BG : FG);
        add(10'd16, 10'd0, 1'b0, 12'h000);
        add(10'd17, 10'd0, 1'b0, 12'h000);
        add(10'd0,  10'd0, 1'b1, BG);
        add(10'd24, 10'd0, 1'b1, BG);
        add(10'd8,  10'd5, 1'b1, FG);
        add(10'd9,  10'd5, 1'b1, BG);

        for (int i = 0; i < tv.size() + 2; i++) begin
            if (i < tv.size()) begin
                drawX  = tv[i].x;
                drawY  = tv[i].y;
                vde_in = tv[i].vde;
            end else begin
                vde_in = 1'b0;
            end
            tick();
            if (i >= 2) begin
                check($sformatf("vec%0d_rgb", i - 2),
                      {20'd0, red, green, blue}, {20'd0, tv[i - 2].rgb});
                check($sformatf("vec%0d_vde", i - 2),
                      {31'd0, vde_out}, {31'd0, tv[i - 2].vde});
            end
        end

        // cell lookup at (17,35): k=162, word 40, byte 2, glyph row 3, bit 6
        drawX  = 10'd17;
        drawY  = 10'd35;
        vde_in = 1'b1;
        #1;
        check("lookup_vram_addr", {22'd0, vram_addr}, 32'd40);
        tick();
        vde_in = 1'b0;
        check("lookup_font_addr", {21'd0, font_addr}, 32'h423);
        tick();
        tick();
        check("lookup_pixel", {20'd0, red, green, blue}, {20'd0, FG});
        pix(10'd16, 10'd35, BG, "lookup_bit7");

        drawX = 10'd640; drawY = 10'd0;
        #1 check("oob_x_addr", {22'd0, vram_addr}, 32'd0);
        drawX = 10'd0; drawY = 10'd480;
        #1 check("oob_y_addr", {22'd0, vram_addr}, 32'd0);
        drawX = 10'd639; drawY = 10'd479;
        #1 check("last_cell_addr", {22'd0, vram_addr}, 32'd599);
        tick();

        // cursor at (5,2): pixels x 40..47, y 46/47
        pix(10'd40, 10'd46, FG, "cur_row14");
        pix(10'd47, 10'd47, FG, "cur_row15");
        pix(10'd40, 10'd45, BG, "cur_row13");
        pix(10'd48, 10'd46, BG, "cur_col6");
        vs_pulses(29);
        pix(10'd40, 10'd46, FG, "cur_frame29");
        vs_pulses(1);
        pix(10'd40, 10'd46, BG, "cur_frame30");
        vs_pulses(29);
        pix(10'd40, 10'd46, BG, "cur_frame59");
        vs_pulses(1);
        pix(10'd40, 10'd46, FG, "cur_frame60");
        cursor_x = 7'd80;
        pix(10'd40, 10'd46, BG, "cur_x80");
        cursor_x  = 7'd5;
        cursor_en = 1'b0;
        pix(10'd40, 10'd46, BG, "cur_disabled");
        cursor_en = 1'b1;
        vs_pulses(30);
        pix(10'd40, 10'd46, BG, "cur_off_before_reset");

        // mid-line reset with a full pipeline
        drawX  = 10'd8;
        drawY  = 10'd0;
        vde_in = 1'b1;
        hs_in  = 1'b1;
        tick();
        tick();
        tick();
        check("pre_reset_rgb", {20'd0, red, green, blue}, {20'd0, FG});
        check("pre_reset_hs", {31'd0, hs_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check("async_reset_sync", {29'd0, hs_out, vs_out, vde_out}, 32'd0);
        vde_in = 1'b0;
        hs_in  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        pix(10'd40, 10'd46, FG, "blink_after_reset");
        vs_pulses(29);
        pix(10'd40, 10'd46, FG, "cnt_after_reset29");
        vs_pulses(1);
        pix(10'd40, 10'd46, BG, "cnt_after_reset30");

        // hsync pulse at drawX=656, width 5, delayed 3 clocks
        for (int i = 0; i < 14; i++) begin
            drawX      = 10'(654 + i);
            hs_in      = (i >= 2 && i < 7);
            hs_hist[i] = hs_in;
            tick();
            if (i >= 2)
                check($sformatf("hs_delay%0d", i - 2),
                      {31'd0, hs_out}, {31'd0, hs_hist[i - 2]});
        end

        // single vsync pulse delayed 3 clocks
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        check("vs_delay1", {31'd0, vs_out}, 32'd0);
        tick();
        check("vs_delay2", {31'd0, vs_out}, 32'd0);
        tick();
        check("vs_delay3", {31'd0, vs_out}, 32'd1);
        tick();
        check("vs_delay4", {31'd0, vs_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_pixel_pipe.md
TEXT_PIXEL_PIPE -- requirements
Module: text_pixel_pipe

Interface
REQ-001 SHALL have parameter H_CHARS, default 80, text columns per row.
REQ-002 SHALL have parameter V_CHARS, default 30, text rows per frame.
REQ-003 SHALL have ports: pixel_clk  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: drawX  in  10  pixel column; drawY  in  10  pixel row; hs_in, vs_in, vde_in  in  1 each  sync/active-video from the VGA sync generator.
REQ-005 SHALL have ports: vram_addr  out  10  word address; vram_rdata  in  32  word data, valid one clock after vram_addr.
REQ-006 SHALL have ports: font_addr  out  11  {code[6:0], glyph_row[3:0]}; font_data  in  8  glyph row, valid one clock after font_addr, bit7 = leftmost pixel.
REQ-007 SHALL have ports: fg_color, bg_color  in  12  {R,G,B} 4b each; cursor_x  in  7; cursor_y  in  5; cursor_en  in  1.
REQ-008 SHALL have ports: red, green, blue  out  4 each; hs_out, vs_out, vde_out  out  1 each, to the HDMI transmitter.

Function
REQ-009 SHALL map 8x16-pixel cells: col = drawX[9:3], row = drawY[9:4], glyph_row = drawY[3:0], bit = drawX[2:0].
REQ-010 SHALL pack 4 chars per VRAM word, char index k = row*H_CHARS + col, vram_addr = k>>2, byte k[1:0] at bits [8*k[1:0]+7 : 8*k[1:0]].
REQ-011 SHALL treat char byte bit7 as invert flag, bits[6:0] as glyph code.
REQ-012 SHALL drive vram_addr combinationally from drawX/drawY in cycle t; drawX>=8*H_CHARS or drawY>=16*V_CHARS drives vram_addr = 0.
REQ-013 SHALL, in t+1, select byte using col[1:0] delayed one clock and drive font_addr combinationally from selected code and delayed glyph_row.
REQ-014 SHALL, in t+2, select pixel font_data[7 - bit] using bit delayed two clocks; pixel = glyph bit XOR invert XOR cursor_hit.
REQ-015 SHALL register red/green/blue at end of t+2: fg_color if pixel=1 else bg_color; total latency 3 clocks from drawX/drawY to RGB.
REQ-016 SHALL delay hs_in, vs_in, vde_in by exactly 3 clocks to hs_out, vs_out, vde_out.
REQ-017 SHALL force RGB = 0 whenever delayed vde (vde_out in same cycle) is 0.
REQ-018 SHALL assert cursor_hit when cursor_en=1, blink_on=1, col=cursor_x, row=cursor_y, glyph_row in {14,15}.
REQ-019 SHALL never hit when cursor_x>=H_CHARS or cursor_y>=V_CHARS.
REQ-020 SHALL keep a 5b frame counter incremented on each vs_in 1->0 edge (registered edge detect); at 29 it wraps to 0 and toggles blink_on (blink period 60 frames).
REQ-021 SHALL sample fg_color, bg_color, cursor_* each clock (no shadowing); mid-frame changes take effect with the 3-clock latency.
REQ-022 SHALL be fully pipelined: one pixel per clock, no stalls, no backpressure.

Reset
REQ-023 SHALL on reset=1 asynchronously clear all pipeline registers: red/green/blue = 0, hs_out = vs_out = vde_out = 0.
REQ-024 SHALL on reset set frame counter = 0, blink_on = 1, vs edge detector = 0.
REQ-025 SHALL produce valid outputs starting the third rising edge after reset deassertion with valid inputs; reset mid-frame discards in-flight pixels.

Verification
REQ-026 Cell lookup: drawX=17, drawY=35 -> vram_addr=40 (k=162), byte 2 selected, font_addr={code,4'd3}, pixel bit 6.
REQ-027 Colors: char 0x41, font_data=8'h80, drawX=8, vde=1, fg=12'hF00, bg=12'h00F -> 3 clocks later RGB=F,0,0; next 7 pixels RGB=0,0,F.
REQ-028 Invert: char 0xC1 same glyph -> first pixel RGB=bg, rest fg; vde_in=0 same pixels -> RGB=0 and vde_out=0 three clocks later.
REQ-029 Cursor blink: cursor_en=1 at (5,2), glyph rows 14/15 inverted frames 0-29, not inverted frames 30-59, inverted again frame 60; cursor_x=80 -> never inverted.
REQ-030 Sync/reset: hs_in pulse aligned with drawX=656 -> hs_out 3 clocks later, same width; reset asserted mid-line -> all outputs 0 immediately, blink_on=1, counter=0.
